// File: rtl/adder_frame_loader.sv
// adder_frame_loader
// Byte-serial front end for the 32-bit prefix-carry fast adder.
// It collects a 9-byte little-endian frame (A, B, flags) into the adder's
// operand registers. After one settle cycle it captures the adder result and
// presents it on a valid/ready port. Only one operation is in flight at a time.
// Optional feature: define ADDER_OVF_EN to enable the captured two's-complement
// overflow flag on res_ovf. Without it, res_ovf is tied to 0.

module adder_frame_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf
);

  typedef enum logic [2:0] {
    LOAD_A,
    LOAD_B,
    LOAD_F,
    EVAL,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic       accept;

  assign accept = in_valid && in_ready;

  // Drop each accepted byte into its lane of the operand registers. These
  // registers change only here, so the adder inputs stay stable during EVAL and HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= 32'd0;
      op_b   <= 32'd0;
      op_cin <= 1'b0;
    end else if (accept) begin
      case (idx)
        4'd0: op_a[7:0]   <= in_data;
        4'd1: op_a[15:8]  <= in_data;
        4'd2: op_a[23:16] <= in_data;
        4'd3: op_a[31:24] <= in_data;
        4'd4: op_b[7:0]   <= in_data;
        4'd5: op_b[15:8]  <= in_data;
        4'd6: op_b[23:16] <= in_data;
        4'd7: op_b[31:24] <= in_data;
        4'd8: op_cin      <= in_data[0];
        default: ;
      endcase
    end
  end

  // Frame sequencer. It also drives the registered in_ready and res_valid
  // flags. in_ready rises on the first edge after reset release, so the first
  // byte can be taken on the cycle after that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD_A;
      idx       <= 4'd0;
      in_ready  <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A, LOAD_B, LOAD_F: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (idx == 4'd8) begin
              idx      <= 4'd0;
              in_ready <= 1'b0;
              state    <= EVAL;
            end else begin
              idx <= idx + 4'd1;
              if (idx == 4'd3) state <= LOAD_B;
              if (idx == 4'd7) state <= LOAD_F;
            end
          end
        end
        EVAL: begin
          in_ready  <= 1'b0;
          res_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= LOAD_A;
          end
        end
        default: begin
          state     <= LOAD_A;
          idx       <= 4'd0;
          in_ready  <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Capture the settled adder output on the EVAL edge. The result then holds
  // until the next capture, so it cannot be overwritten before its handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_sum  <= 32'd0;
      res_cout <= 1'b0;
    end else if (state == EVAL) begin
      res_sum  <= add_sum;
      res_cout <= add_cout;
    end
  end

`ifdef ADDER_OVF_EN
  // Signed overflow occurs when both operands share a sign and the sum's sign
  // differs from it. It is captured alongside the sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_ovf <= 1'b0;
    end else if (state == EVAL) begin
      res_ovf <= (op_a[31] == op_b[31]) && (add_sum[31] != op_a[31]);
    end
  end
`else
  assign res_ovf = 1'b0;
`endif

endmodule

// File: doc/adder_frame_loader.md
# adder_frame_loader

Byte-serial front end for the 32-bit prefix-carry fast adder. It assembles two 32-bit operands and a carry-in from a valid/ready byte stream and drives them onto the adder's operand inputs. After one settle cycle it captures the adder's sum and carry-out into result registers. It then presents the result on a valid/ready output port, making the combinational adder usable from a byte-wide bus with exactly one operation in flight.

## Interface
- No parameters. Widths are fixed: 8-bit input bytes, 32-bit operands.
- `clk  in  1  single clock; all state updates on rising edge`
- `rst  in  1  asynchronous, active-high reset`
- `in_valid  in  1  upstream byte valid`
- `in_ready  out  1  loader accepts a byte this cycle`
- `in_data  in  8  frame byte`
- `op_a  out  32  operand A to adder`
- `op_b  out  32  operand B to adder`
- `op_cin  out  1  carry-in to adder`
- `add_sum  in  32  sum from adder (combinational from op_a/op_b/op_cin)`
- `add_cout  in  1  carry-out from adder (bit 32 of carry chain)`
- `res_valid  out  1  result available`
- `res_ready  in  1  downstream accepts result`
- `res_sum  out  32  captured sum`
- `res_cout  out  1  captured carry-out`
- `res_ovf  out  1  captured signed overflow (see Configuration)`

## Operation
- Frame is 9 bytes, little-endian:
  - bytes 0–3: A[7:0]..A[31:24]
  - bytes 4–7: B[7:0]..B[31:24]
  - byte 8: flags. bit0 = cin; bits 7:1 are ignored.
- A byte is accepted when `in_valid && in_ready`. A 4-bit byte index counts 0..8.
- FSM states:
  - LOAD_A (idx 0–3), LOAD_B (idx 4–7), LOAD_F (idx 8), EVAL, HOLD.
  - LOAD_A→LOAD_B after byte 3 is accepted.
  - LOAD_B→LOAD_F after byte 7 is accepted.
  - LOAD_F→EVAL on the byte-8 accept.
  - EVAL→HOLD unconditionally after 1 cycle.
  - HOLD→LOAD_A on `res_valid && res_ready`.
- `in_ready` = 1 in LOAD_A/LOAD_B/LOAD_F only; 0 in EVAL and HOLD.
- Accepted bytes are written directly into the byte lanes of the `op_a`/`op_b`/`op_cin` registers. These registers change only on accepts, so the adder inputs stay stable through EVAL and HOLD.
- Capture: on the EVAL clock edge, `res_sum <= add_sum` and `res_cout <= add_cout`. `res_ovf` is loaded as described in Configuration.
- Result registers are held unchanged in HOLD and stay unchanged until the next capture. `res_valid` = 1 exactly in HOLD.
- `in_valid` while `in_ready` = 0 is ignored; no byte is consumed.
- Flag bits 7:1 have no effect.

## Timing
- Reset values:
  - state = LOAD_A, idx = 0.
  - `op_a` = 0, `op_b` = 0, `op_cin` = 0.
  - `res_sum` = 0, `res_cout` = 0, `res_ovf` = 0, `res_valid` = 0.
  - `in_ready` = 0 while `rst` is high; 1 from the first cycle after release.
- Latency: byte 8 accepted at edge N → EVAL during cycle N..N+1 → capture at edge N+1 → `res_valid` high from N+1.
- With a continuous stream and `res_ready` = 1, throughput is one frame per 11 cycles (9 load + EVAL + HOLD).
- HOLD with `res_ready` = 1: handshake completes in that cycle. The next cycle is LOAD_A with `in_ready` = 1 and `res_valid` = 0.
- A result is never overwritten before its handshake.
- The first frame byte can be accepted in the same cycle `in_ready` rises.
- Reset mid-frame or in HOLD discards partial operands and any pending result; all outputs return to reset values immediately (asynchronous).
- Arithmetic is performed by the adder. The loader adds no width extension: `res_cout` is the 33rd bit.

## Configuration
- Macro `ADDER_OVF_EN` controls the overflow flag.
- Defined: on the EVAL edge, `res_ovf <= (op_a[31] == op_b[31]) && (add_sum[31] != op_a[31])` (two's-complement overflow).
- Undefined: `res_ovf` is constant 0, and no overflow logic is synthesized.

## Test plan
- Reset release, then A=C090F0D0, B=CF00FADB, flags=01 → `res_sum`=8F91EBAC, `res_cout`=1, `res_ovf`=0; `res_valid` rises exactly 1 cycle after the byte-8 accept.
- Same operands, flags=00 → `res_sum`=8F91EBAB, `res_cout`=1; flags=FE (cin=0, junk upper bits) gives an identical result.
- A=7FFFFFFF, B=00000001, cin=0 → `res_sum`=80000000, `res_cout`=0, `res_ovf`=1 (0 when `ADDER_OVF_EN` is undefined). A=FFFFFFFF, B=00000000, cin=1 → `res_sum`=00000000, `res_cout`=1, `res_ovf`=0.
- Backpressure: hold `res_ready`=0 for 5 cycles with `in_valid`=1 → `in_ready`=0, the result is stable, and no bytes are consumed. Raise `res_ready` → a single handshake, then the next frame loads correctly.
- Send 5 bytes, assert `rst` for 1 cycle, then send a full frame A=00000002, B=00000003, cin=0 → `res_sum`=00000005; the stale partial bytes have no effect.
- Stream with random `in_valid` gaps → operands are assembled correctly with no byte dropped or duplicated.
